seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an 8-digit 7-segment display.
- Holds 8 hex nibbles plus decimal-point bits and steps a 3-bit digit index at a programmable refresh rate.
- Drives the active-low segment pattern for the selected digit.
- `sel` feeds the downstream 3-to-8 active-low digit-select decoder directly, so `sel`, `seg_n` and `dp_n` stay aligned in the same cycle.

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_scan_ctrl_hex_to_seg.sv | 19 +
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared types and constants for the 8-digit 7-segment scan
//            controller: digit count, nibble/segment types, the blank
//            pattern and the active-low hex glyph table (gfedcba).
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // All segments off (active-low)
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit6=g ... bit0=a
  localparam seg_t SEG_LUT [0:15] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg
// Purpose  : Combinational hex nibble to active-low 7-segment glyph decode.
// Ports    : nib  - input nibble
//            seg  - active-low segment pattern (bit0=a ... bit6=g)
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg
  import seg_pkg::*;
(
  input  nibble_t nib,
  output seg_t    seg
);

  assign seg = SEG_LUT[nib];

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for an 8-digit 7-segment
//            display. A prescaler advances a 3-bit digit index every
//            REFRESH_DIV cycles; new display words are double-buffered and
//            only swapped in at a frame wrap so a frame never tears.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            wr_valid/wr_ready   - display word handshake
//            wr_data, wr_dp      - hex nibbles and decimal points (digit k)
//            digit_en            - live per-digit enable (0 blanks)
//            sel                 - current digit index to 3-to-8 decoder
//            seg_n, dp_n         - active-low segments / decimal point
//            frame_done          - one-cycle pulse when sel wraps 7->0
// Options  : SEG_LEADING_ZERO_BLANK_EN - when defined, digits above the
//            most-significant nonzero nibble are blanked (digit 0 and any
//            digit with its dp set are exempt).
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  digit_en,
  output logic [2:0]  sel,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             frame_done_q, frame_done_d;
  logic             pend_full_q, pend_full_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic [31:0]      disp_data_q, disp_data_d;
  logic [7:0]       disp_dp_q, disp_dp_d;

  logic    tick;
  logic    wrap;
  logic    accept;
  nibble_t cur_nib;
  seg_t    cur_seg;
  logic    lz_blank;
  logic    blank;

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    wrap   = tick && (sel_q == 3'd7);
    accept = wr_valid && !pend_full_q;

    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    sel_d        = tick ? sel_q + 3'd1 : sel_q;
    frame_done_d = wrap;

    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;

    // Swap only on the 7->0 step so the next frame shows one word throughout
    if (wrap && pend_full_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end
    // accept implies pending empty, so it never collides with the swap above
    if (accept) begin
      pend_data_d = wr_data;
      pend_dp_d   = wr_dp;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      frame_done_q <= 1'b0;
      pend_full_q  <= 1'b0;
      pend_data_q  <= 32'd0;
      pend_dp_q    <= 8'd0;
      disp_data_q  <= 32'd0;
      disp_dp_q    <= 8'd0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
      pend_full_q  <= pend_full_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
    end
  end

  assign cur_nib = disp_data_q[{sel_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nib (cur_nib),
    .seg (cur_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [2:0] msd;

  // Index of the most-significant nonzero nibble; 0 when the word is zero,
  // which keeps digit 0 always visible.
  always_comb begin
    msd = 3'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (disp_data_q[4*k +: 4] != 4'h0) msd = 3'(k);
    end
  end

  assign lz_blank = (sel_q > msd) && !disp_dp_q[sel_q];
`else
  assign lz_blank = 1'b0;
`endif

  assign blank = !digit_en[sel_q] || lz_blank;

  assign seg_n      = blank ? SEG_BLANK : cur_seg;
  assign dp_n       = blank || !disp_dp_q[sel_q];
  assign sel        = sel_q;
  assign frame_done = frame_done_q;
  assign wr_ready   = !pend_full_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Randomized scoreboard bench for seg_scan_ctrl (REFRESH_DIV=4).
//            A driver updates a cycle-count reference model and queues the
//            expected outputs; a monitor pops and compares on each negedge.
// Revision : 1.1 - per-output comparisons
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int DIV    = 4;
    localparam int FRAME  = DIV * 8;
    localparam int NCYC   = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic [7:0]  wr_dp = 8'd0;
    logic [7:0]  digit_en = 8'hFF;
    logic        wr_ready;
    logic [2:0]  sel;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .digit_en   (digit_en),
        .sel        (sel),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic [6:0] seg_n;
        logic       dp_n;
        logic       wr_ready;
        logic       frame_done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   queued      = 0;
    int   miscompares = 0;
    bit   drv_done    = 0;

    int          t;
    logic [31:0] m_disp, m_pend;
    logic [7:0]  m_disp_dp, m_pend_dp;
    bit          m_full, m_fd, m_accepted;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
        endcase
    endfunction

    task automatic model_edge();
        bit wrap;
        if (!rst_n) begin
            t = 0; m_disp = 0; m_disp_dp = 0; m_pend = 0; m_pend_dp = 0;
            m_full = 0; m_fd = 0; m_accepted = 0;
        end else begin
            wrap       = (t % FRAME) == FRAME - 1;
            m_accepted = wr_valid && !m_full;
            if (wrap && m_full) begin
                m_disp = m_pend; m_disp_dp = m_pend_dp; m_full = 0;
            end
            if (m_accepted) begin
                m_pend = wr_data; m_pend_dp = wr_dp; m_full = 1;
            end
            m_fd = wrap;
            t++;
        end
    endtask

    function automatic exp_t expect_now();
        exp_t       e;
        int         s;
        logic [3:0] nib;
        bit         blank;
        int         msd;
        s     = (t / DIV) % 8;
        nib   = m_disp[4*s +: 4];
        blank = !digit_en[s];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        msd = 0;
        for (int k = 0; k < 8; k++) if (m_disp[4*k +: 4] != 0) msd = k;
        if (s > msd && !m_disp_dp[s]) blank = 1;
`else
        msd = 0;
`endif
        e.sel        = 3'(s);
        e.seg_n      = blank ? 7'h7F : glyph(nib);
        e.dp_n       = blank ? 1'b1 : !m_disp_dp[s];
        e.wr_ready   = !m_full;
        e.frame_done = m_fd;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    initial begin
        logic [31:0] words [0:2];
        logic [7:0]  dps   [0:2];
        int          widx;
        words[0] = 32'h76543210; dps[0] = 8'h01;
        words[1] = 32'h12345678; dps[1] = 8'h00;
        words[2] = 32'h00000A05; dps[2] = 8'h00;
        widx = 0;

        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) rst_n = 1'b1;
            exp_q.push_back(expect_now());
            queued++;
        end

        for (int i = 0; i < NCYC; i++) begin
            step();
            if (!wr_valid || m_accepted) begin
                wr_valid = (i == 0) || ($urandom_range(0, 3) == 0);
                if (wr_valid) begin
                    if (widx < 3) begin
                        wr_data = words[widx]; wr_dp = dps[widx]; widx++;
                    end else begin
                        wr_data = $urandom;
                        wr_data = wr_data >> (4 * $urandom_range(0, 7));
                        wr_dp   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                    end
                end
            end
            if (i == 1500)
                digit_en = 8'h0F;
            else if (i > 1500 && (i % 64) == 0)
                digit_en = 8'($urandom);
            rst_n = !((i == 1000) || (i > 200 && $urandom_range(0, 299) == 0));
            exp_q.push_back(expect_now());
            queued++;
        end
        drv_done = 1;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (sel !== e.sel) begin
                    miscompares++;
                    $display("FAIL sel @%0t: got %0d, expected %0d", $time, sel, e.sel);
                end
                if (seg_n !== e.seg_n) begin
                    miscompares++;
                    $display("FAIL seg_n @%0t: got %b, expected %b", $time, seg_n, e.seg_n);
                end
                if (dp_n !== e.dp_n) begin
                    miscompares++;
                    $display("FAIL dp_n @%0t: got %b, expected %b", $time, dp_n, e.dp_n);
                end
                if (wr_ready !== e.wr_ready) begin
                    miscompares++;
                    $display("FAIL wr_ready @%0t: got %b, expected %b", $time, wr_ready, e.wr_ready);
                end
                if (frame_done !== e.frame_done) begin
                    miscompares++;
                    $display("FAIL frame_done @%0t: got %b, expected %b", $time, frame_done, e.frame_done);
                end
            end
            if (drv_done && exp_q.size() == 0) break;
        end
        if (vectors != queued) begin
            miscompares++;
            $display("FAIL vector count: got %0d, expected %0d", vectors, queued);
        end
        if (miscompares != 0)
            $display("FAIL summary: got %0d miscompares, expected 0", miscompares);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #(NCYC * 10 * 4);
        $display("FAIL timeout: got no completion, expected %0d cycles", NCYC);
        $fatal(1);
    end

endmodule
`default_nettype wire
